// File: rtl/pc_unit.sv
// Registered program-counter unit: NVZ branch evaluation, sequential/relative/indirect
// flow changes, a hardware return-address stack and a RUN/HALT state machine.
module pc_unit #(
  parameter int          W        = 16,
  parameter int          IMM_W    = 10,
  parameter int          INC      = 2,
  parameter int unsigned RESET_PC = 0,
  parameter int          DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       bsig,
  input  logic [2:0]       C,
  input  logic [IMM_W-1:0] I,
  input  logic [2:0]       F,
  input  logic [W-1:0]     regsrc,
  output logic [W-1:0]     pc_out,
  output logic [W-1:0]     pc_next,
  output logic             halted,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             stk_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   stack_mem [DEPTH];
  logic [CW-1:0]  count, count_next;
  logic [W-1:0]   seq, tgt, imm_ext;
  logic [AW-1:0]  top_idx;
  logic           take, push, err_set, is_full, is_empty;

  assign seq      = pc_out + W'(INC);
  assign imm_ext  = {{(W-IMM_W){I[IMM_W-1]}}, I};
  assign tgt      = seq + imm_ext;
  assign top_idx  = AW'(count - CW'(1));
  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);
  assign halted   = (state == HALT);

  // GTE (100) reduces to Z | ~N; written out to mirror the flag definition.
  always_comb begin
    take = 1'b0;
    case (C)
      3'b000:  take = ~F[0];
      3'b001:  take = F[0];
      3'b010:  take = ~F[0] & ~F[2];
      3'b011:  take = F[2];
      3'b100:  take = F[0] | (~F[0] & ~F[2]);
      3'b101:  take = F[2] | F[0];
      3'b110:  take = F[1];
      default: take = 1'b1;
    endcase
  end

  always_comb begin
    pc_next    = pc_out;
    state_next = state;
    count_next = count;
    push       = 1'b0;
    err_set    = 1'b0;
    if (state == RUN && !stall) begin
      case (bsig)
        3'b001: pc_next = take ? tgt : seq;
        3'b010: pc_next = take ? regsrc : seq;
        3'b011: state_next = HALT;
        3'b100: begin
          pc_next = seq;
          if (take) begin
            if (!is_full) begin
              push       = 1'b1;
              count_next = count + CW'(1);
              pc_next    = tgt;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        3'b101: begin
          pc_next = seq;
          if (take) begin
            if (!is_empty) begin
              count_next = count - CW'(1);
              pc_next    = stack_mem[top_idx];
            end else begin
              err_set = 1'b1;
            end
          end
        end
        default: pc_next = seq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out    <= W'(RESET_PC);
      state     <= RUN;
      count     <= '0;
      stk_empty <= 1'b1;
      stk_full  <= 1'b0;
      stk_err   <= 1'b0;
    end else begin
      pc_out    <= pc_next;
      state     <= state_next;
      count     <= count_next;
      stk_empty <= (count_next == '0);
      stk_full  <= (count_next == CW'(DEPTH));
      if (err_set) stk_err <= 1'b1;
    end
  end

  // Stack storage needs no reset: entries above count are never read.
  always_ff @(posedge clk) begin
    if (push) stack_mem[count[AW-1:0]] <= seq;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed flow-change scenarios plus a randomized phase, all checked
// against a queue-based behavioural model of the PC, return stack and halt flag.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  bsig, C, F;
  logic [9:0]  I;
  logic [15:0] regsrc;
  logic [15:0] pc_out, pc_next;
  logic        halted, stk_empty, stk_full, stk_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  bit          m_err;
  bit          m_halt;

  pc_unit dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .bsig      (bsig),
    .C         (C),
    .I         (I),
    .F         (F),
    .regsrc    (regsrc),
    .pc_out    (pc_out),
    .pc_next   (pc_next),
    .halted    (halted),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .stk_err   (stk_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit condTrue(input logic [2:0] c, input logic [2:0] f);
    bit n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ":pc_out"}, {16'h0, pc_out}, {16'h0, m_pc});
    checkOutput({tag, ":halted"}, {31'h0, halted}, {31'h0, m_halt});
    checkOutput({tag, ":empty"}, {31'h0, stk_empty}, (m_stack.size() == 0) ? 1 : 0);
    checkOutput({tag, ":full"}, {31'h0, stk_full}, (m_stack.size() == 4) ? 1 : 0);
    checkOutput({tag, ":err"}, {31'h0, stk_err}, {31'h0, m_err});
  endtask

  // Called at a falling edge: drive inputs, check pc_next, clock once, check state.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] c, input logic [9:0] imm,
                               input logic [2:0] f, input logic [15:0] rs, input logic st,
                               input string tag);
    logic [15:0] s, t, nxt;
    bit take, do_push, do_pop, go_halt;
    bsig = op; C = c; I = imm; F = f; regsrc = rs; stall = st;
    #1;
    s = m_pc + 16'd2;
    t = s + {{6{imm[9]}}, imm};
    take = condTrue(c, f);
    nxt = m_pc; do_push = 0; do_pop = 0; go_halt = 0;
    if (!st && !m_halt) begin
      case (op)
        3'd1: nxt = take ? t : s;
        3'd2: nxt = take ? rs : s;
        3'd3: go_halt = 1;
        3'd4: begin
          nxt = s;
          if (take && m_stack.size() < 4) begin do_push = 1; nxt = t; end
          else if (take) m_err = 1;
        end
        3'd5: begin
          nxt = s;
          if (take && m_stack.size() > 0) begin do_pop = 1; nxt = m_stack[$]; end
          else if (take) m_err = 1;
        end
        default: nxt = s;
      endcase
    end
    checkOutput({tag, ":pc_next"}, {16'h0, pc_next}, {16'h0, nxt});
    @(posedge clk);
    @(negedge clk);
    if (do_push) m_stack.push_back(s);
    if (do_pop) void'(m_stack.pop_back());
    if (go_halt) m_halt = 1;
    m_pc = nxt;
    checkState(tag);
  endtask

  task automatic modelReset();
    m_pc = 16'h0; m_stack.delete(); m_err = 0; m_halt = 0;
  endtask

  // Reset lands mid-high-phase, after the edge has already updated state.
  task automatic doReset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkState(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic jump(input logic [15:0] target);
    applyStimulus(3'd2, 3'd7, 10'h0, 3'd0, target, 1'b0, "jump");
  endtask

  initial begin
    logic [2:0]  op, c;
    int          r, halt_age;
    rst = 1'b1; stall = 1'b0; bsig = 3'd0; C = 3'd0; I = '0; F = 3'd0; regsrc = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkState("reset");
    rst = 1'b0;

    for (int k = 0; k < 3; k++) applyStimulus(3'd0, 3'd0, 10'h0, 3'd0, 16'h0, 1'b0, "seq");
    checkOutput("seq3_const", {16'h0, pc_out}, 32'h6);

    jump(16'h0010);
    applyStimulus(3'd1, 3'd4, 10'h3FF, 3'b000, 16'h0, 1'b0, "gte_taken");
    checkOutput("gte_taken_const", {16'h0, pc_out}, 32'h11);
    jump(16'h0010);
    applyStimulus(3'd1, 3'd4, 10'h3FF, 3'b100, 16'h0, 1'b0, "gte_not");
    checkOutput("gte_not_const", {16'h0, pc_out}, 32'h12);

    jump(16'h0020);
    applyStimulus(3'd4, 3'd7, 10'h010, 3'd0, 16'h0, 1'b0, "call");
    checkOutput("call_const", {16'h0, pc_out}, 32'h32);
    applyStimulus(3'd5, 3'd7, 10'h0, 3'd0, 16'h0, 1'b0, "ret");
    checkOutput("ret_const", {16'h0, pc_out}, 32'h22);

    jump(16'h0100);
    for (int k = 0; k < 5; k++) applyStimulus(3'd4, 3'd7, 10'h010, 3'd0, 16'h0, 1'b0, "call5");
    checkOutput("overflow_err", {31'h0, stk_err}, 32'h1);
    for (int k = 0; k < 5; k++) applyStimulus(3'd5, 3'd7, 10'h0, 3'd0, 16'h0, 1'b0, "ret5");

    jump(16'hFFFE);
    applyStimulus(3'd0, 3'd0, 10'h0, 3'd0, 16'h0, 1'b0, "wrap");
    checkOutput("wrap_const", {16'h0, pc_out}, 32'h0);

    jump(16'h0030);
    for (int k = 0; k < 3; k++) applyStimulus(3'd1, 3'd7, 10'h004, 3'd0, 16'h0, 1'b1, "stall");
    applyStimulus(3'd1, 3'd7, 10'h004, 3'd0, 16'h0, 1'b0, "unstall");
    checkOutput("unstall_const", {16'h0, pc_out}, 32'h36);

    jump(16'h0040);
    applyStimulus(3'd3, 3'd0, 10'h0, 3'd0, 16'h0, 1'b0, "hlt");
    for (int k = 0; k < 10; k++)
      applyStimulus(3'($urandom_range(0, 5)), 3'd7, 10'($urandom), 3'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), "halted");
    checkOutput("halt_pc_const", {16'h0, pc_out}, 32'h40);
    doReset("async_rst");

    halt_age = 0;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 15);
      if (r < 4) op = 3'd0;
      else if (r < 7) op = 3'd1;
      else if (r < 8) op = 3'd2;
      else if (r < 9) op = 3'd3;
      else if (r < 12) op = 3'd4;
      else if (r < 15) op = 3'd5;
      else op = 3'($urandom_range(6, 7));
      c = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'($urandom);
      applyStimulus(op, c, 10'($urandom), 3'($urandom), 16'($urandom),
                    ($urandom_range(0, 7) == 0), "rand");
      if (m_halt) halt_age++;
      if (halt_age > 3 || $urandom_range(0, 60) == 0) begin
        doReset("rand_rst");
        halt_age = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
